// File: rtl/store_unit_pkg.sv
// Shared store-path definitions: opcode encodings, size masks and a decode helper.
package store_unit_pkg;

  // Store opcodes carried in instruction_data[2:0]
  localparam logic [2:0] OP_SB = 3'b000;
  localparam logic [2:0] OP_SH = 3'b001;
  localparam logic [2:0] OP_SW = 3'b010;

  // Byte-enable masks for an access at lane offset 0
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Size mask for a store opcode; all-zero marks an illegal opcode
  function automatic logic [3:0] size_mask(input logic [2:0] op);
    case (op)
      OP_SB:   size_mask = MASK_B;
      OP_SH:   size_mask = MASK_H;
      OP_SW:   size_mask = MASK_W;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_unit_lane_align.sv
// Combinational lane alignment: opcode + byte offset + data -> 8-lane enables and
// 64-bit shifted data spanning two consecutive words, plus split/illegal flags.
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  be8,
  output logic [63:0] data64,
  output logic        needs_split,
  output logic        illegal
);

  logic [3:0] mask;

  // Shift the size mask and the data into position across two words
  always_comb begin
    mask        = size_mask(op);
    illegal     = (mask == 4'b0000);
    be8         = {4'b0000, mask} << off;
    data64      = {32'h0000_0000, data} << {off, 3'b000};
    needs_split = |be8[7:4];
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store per handshake, issues one or two word-aligned
// write beats over req/ack, and reports completion with a one-cycle done pulse.
module store_unit
  import store_unit_pkg::*;
#(
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instruction_data,
  input  logic [31:0] data_address,
  input  logic [31:0] write_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  // Wait counter sized to hold TIMEOUT_CYCLES-1; the compare value is the last
  // unacknowledged cycle before the beat is abandoned.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t            state_reg;
  logic              req_ready_reg;
  logic              mem_req_reg;
  logic [31:0]       mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [3:0]        mem_be_reg;
  logic              done_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  // Upper-word half of the request, held for the second beat of a split store
  logic              split_reg;
  logic [31:0]       wdata_hi_reg;
  logic [3:0]        be_hi_reg;

  logic [7:0]        be8;
  logic [63:0]       data64;
  logic              needs_split;
  logic              illegal;
  logic              timeout_hit;
  logic              unused_instr;

  // Opcode bits above [2:0] carry no meaning for stores
  assign unused_instr = ^instruction_data[31:3];

  // Alignment is computed straight from the request so the first beat can be
  // registered on the accepting edge.
  store_lane_align u_align (
    .op          (instruction_data[2:0]),
    .off         (data_address[1:0]),
    .data        (write_data),
    .be8         (be8),
    .data64      (data64),
    .needs_split (needs_split),
    .illegal     (illegal)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_reg == WAIT_LAST);

  // Store FSM with fully registered handshake and memory outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      req_ready_reg <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
      mem_be_reg    <= 4'h0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      wait_cnt_reg  <= '0;
      split_reg     <= 1'b0;
      wdata_hi_reg  <= 32'h0;
      be_hi_reg     <= 4'h0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg      <= 1'b0;
          err_reg       <= 1'b0;
          req_ready_reg <= 1'b1;
          if (req_valid && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            if (illegal || (needs_split && !SPLIT_MISALIGNED)) begin
              // Rejected without touching memory
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
              state_reg <= S_RESP;
            end else begin
              mem_req_reg   <= 1'b1;
              mem_addr_reg  <= {data_address[31:2], 2'b00};
              mem_wdata_reg <= data64[31:0];
              mem_be_reg    <= be8[3:0];
              wait_cnt_reg  <= '0;
              split_reg     <= needs_split;
              wdata_hi_reg  <= data64[63:32];
              be_hi_reg     <= be8[7:4];
              state_reg     <= S_BEAT0;
            end
          end
        end
        S_BEAT0, S_BEAT1: begin
          if (mem_ack) begin
            if (state_reg == S_BEAT0 && split_reg) begin
              // Next word; the add wraps naturally at the top of the address space
              mem_addr_reg  <= mem_addr_reg + 32'd4;
              mem_wdata_reg <= wdata_hi_reg;
              mem_be_reg    <= be_hi_reg;
              wait_cnt_reg  <= '0;
              state_reg     <= S_BEAT1;
            end else begin
              mem_req_reg <= 1'b0;
              done_reg    <= 1'b1;
              err_reg     <= 1'b0;
              state_reg   <= S_RESP;
            end
          end else if (timeout_hit) begin
            // Abandon the beat; an already written first beat is not undone
            mem_req_reg <= 1'b0;
            done_reg    <= 1'b1;
            err_reg     <= 1'b1;
            state_reg   <= S_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        S_RESP: begin
          done_reg      <= 1'b0;
          err_reg       <= 1'b0;
          req_ready_reg <= 1'b1;
          state_reg     <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: instance a uses default parameters, instance b
// disallows misaligned splits and times out after 4 unacknowledged cycles.
module tb_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_mem_req, a_mem_ack, a_done, a_err;
  logic [31:0] a_instr, a_addr, a_wdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_req_valid, b_req_ready, b_mem_req, b_mem_ack, b_done, b_err;
  logic [31:0] b_instr, b_addr, b_wdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  store_unit dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .instruction_data(a_instr), .data_address(a_addr), .write_data(a_wdata),
    .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
    .mem_ack(a_mem_ack), .done(a_done), .err(a_err)
  );

  store_unit #(.SPLIT_MISALIGNED(1'b0), .TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .instruction_data(b_instr), .data_address(b_addr), .write_data(b_wdata),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
    .mem_ack(b_mem_ack), .done(b_done), .err(b_err)
  );

  // Bit mask covering the byte lanes enabled by be
  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Present one request to instance a; returns just after the accepting edge
  task automatic send_a(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (a_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL send_a_ready got %b exp 1", a_req_ready); end
    a_req_valid = 1'b1; a_instr = {29'h0, op}; a_addr = addr; a_wdata = data;
    @(posedge clk); #1 a_req_valid = 1'b0;
    $display("store a op=%b addr=%h data=%h accepted at %0t", op, addr, data, $time);
  endtask

  task automatic send_b(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    int n;
    n = 0;
    @(negedge clk);
    while (b_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL send_b_ready got %b exp 1", b_req_ready); end
    b_req_valid = 1'b1; b_instr = {29'h0, op}; b_addr = addr; b_wdata = data;
    @(posedge clk); #1 b_req_valid = 1'b0;
    $display("store b op=%b addr=%h data=%h accepted at %0t", op, addr, data, $time);
  endtask

  // Acknowledge for exactly one edge (called at a negedge)
  task automatic ack_a();
    a_mem_ack = 1'b1; @(posedge clk); #1 a_mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", a_req_ready); end
    checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", a_mem_req); end
    checks++; if (a_done !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b exp 00", a_done, a_err); end
    checks++; if (a_mem_addr !== 32'h0 || a_mem_be !== 4'h0 || a_mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus got %h/%h/%h exp 0", a_mem_addr, a_mem_be, a_mem_wdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", a_req_ready); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready_b got %b exp 1", b_req_ready); end
  endtask

  task automatic test_sw_aligned();
    send_a(3'b010, 32'h0000_1000, 32'hABCD_EF12);
    @(negedge clk);
    checks++; if (a_mem_req !== 1'b1) begin errors++; $display("FAIL sw_mem_req got %b exp 1", a_mem_req); end
    checks++; if (a_mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL sw_addr got %h exp 00001000", a_mem_addr); end
    checks++; if (a_mem_be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b exp 1111", a_mem_be); end
    checks++; if (a_mem_wdata !== 32'hABCD_EF12) begin errors++; $display("FAIL sw_wdata got %h exp abcdef12", a_mem_wdata); end
    checks++; if (a_req_ready !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL sw_busy got ready=%b done=%b exp 0 0", a_req_ready, a_done); end
    ack_a();
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL sw_done got done=%b err=%b exp 1 0", a_done, a_err); end
    checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL sw_req_drop got %b exp 0", a_mem_req); end
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL sw_resp_ready got %b exp 0", a_req_ready); end
    @(negedge clk);
    checks++; if (a_done !== 1'b0 || a_req_ready !== 1'b1) begin errors++; $display("FAIL sw_after got done=%b ready=%b exp 0 1", a_done, a_req_ready); end
  endtask

  task automatic test_sh_sb();
    send_a(3'b001, 32'h0000_1002, 32'h1234_ABCD);
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'h0000_1000 || a_mem_be !== 4'b1100) begin errors++; $display("FAIL sh_addr_be got %h/%b exp 00001000/1100", a_mem_addr, a_mem_be); end
    checks++; if ((a_mem_wdata & lanes(4'b1100)) !== 32'hABCD_0000) begin errors++; $display("FAIL sh_wdata got %h exp abcd----", a_mem_wdata); end
    ack_a();
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL sh_done got done=%b err=%b exp 1 0", a_done, a_err); end
    send_a(3'b000, 32'h0000_1003, 32'h0000_0080);
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'h0000_1000 || a_mem_be !== 4'b1000) begin errors++; $display("FAIL sb_addr_be got %h/%b exp 00001000/1000", a_mem_addr, a_mem_be); end
    checks++; if ((a_mem_wdata & lanes(4'b1000)) !== 32'h8000_0000) begin errors++; $display("FAIL sb_wdata got %h exp 80------", a_mem_wdata); end
    ack_a();
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL sb_done got done=%b err=%b exp 1 0", a_done, a_err); end
  endtask

  task automatic test_illegal();
    send_a(3'b100, 32'h0000_1000, 32'h1111_2222);
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b1) begin errors++; $display("FAIL illegal_done got done=%b err=%b exp 1 1", a_done, a_err); end
    checks++; if (a_mem_req !== 1'b0) begin errors++; $display("FAIL illegal_mem_req got %b exp 0", a_mem_req); end
    @(negedge clk);
    checks++; if (a_mem_req !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL illegal_after got req=%b done=%b exp 0 0", a_mem_req, a_done); end
  endtask

  task automatic test_split();
    send_a(3'b010, 32'h0000_1006, 32'h1122_3344);
    @(negedge clk);
    checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h0000_1004 || a_mem_be !== 4'b1100) begin errors++; $display("FAIL split_b0 got req=%b %h/%b exp 1 00001004/1100", a_mem_req, a_mem_addr, a_mem_be); end
    checks++; if ((a_mem_wdata & lanes(4'b1100)) !== 32'h3344_0000) begin errors++; $display("FAIL split_b0_wdata got %h exp 3344----", a_mem_wdata); end
    ack_a();
    @(negedge clk);
    checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h0000_1008 || a_mem_be !== 4'b0011) begin errors++; $display("FAIL split_b1 got req=%b %h/%b exp 1 00001008/0011", a_mem_req, a_mem_addr, a_mem_be); end
    checks++; if ((a_mem_wdata & lanes(4'b0011)) !== 32'h0000_1122) begin errors++; $display("FAIL split_b1_wdata got %h exp ----1122", a_mem_wdata); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL split_early_done got %b exp 0", a_done); end
    ack_a();
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b0 || a_mem_req !== 1'b0) begin errors++; $display("FAIL split_done got done=%b err=%b req=%b exp 1 0 0", a_done, a_err, a_mem_req); end
  endtask

  task automatic test_nosplit();
    send_b(3'b010, 32'h0000_1006, 32'h1122_3344);
    @(negedge clk);
    checks++; if (b_done !== 1'b1 || b_err !== 1'b1) begin errors++; $display("FAIL nosplit_done got done=%b err=%b exp 1 1", b_done, b_err); end
    checks++; if (b_mem_req !== 1'b0) begin errors++; $display("FAIL nosplit_mem_req got %b exp 0", b_mem_req); end
  endtask

  task automatic test_delayed_ack();
    send_a(3'b010, 32'h0000_3004, 32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h0000_3004 || a_mem_be !== 4'b1111 || a_mem_wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL delay_stable[%0d] got req=%b %h/%b/%h", i, a_mem_req, a_mem_addr, a_mem_be, a_mem_wdata); end
      checks++; if (a_req_ready !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL delay_busy[%0d] got ready=%b done=%b exp 0 0", i, a_req_ready, a_done); end
    end
    ack_a();
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL delay_done got done=%b err=%b exp 1 0", a_done, a_err); end
  endtask

  task automatic test_timeout();
    send_b(3'b010, 32'h0000_2000, 32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (b_mem_req !== 1'b1 || b_done !== 1'b0) begin errors++; $display("FAIL timeout_wait[%0d] got req=%b done=%b exp 1 0", i, b_mem_req, b_done); end
    end
    @(negedge clk);
    checks++; if (b_mem_req !== 1'b0) begin errors++; $display("FAIL timeout_drop got %b exp 0", b_mem_req); end
    checks++; if (b_done !== 1'b1 || b_err !== 1'b1) begin errors++; $display("FAIL timeout_err got done=%b err=%b exp 1 1", b_done, b_err); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    send_a(3'b010, 32'h0000_4000, 32'h5555_AAAA);
    @(negedge clk);
    checks++; if (a_mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b exp 1", a_mem_req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_mem_req !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL rmid_abort got req=%b done=%b err=%b exp 0 0 0", a_mem_req, a_done, a_err); end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin @(negedge clk); if (a_done === 1'b1 || a_mem_req === 1'b1) saw_done = 1'b1; end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmid_no_done got activity=%b exp 0", saw_done); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", a_req_ready); end
  endtask

  task automatic test_wrap();
    send_a(3'b010, 32'hFFFF_FFFE, 32'hCAFE_BABE);
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'hFFFF_FFFC || a_mem_be !== 4'b1100 || (a_mem_wdata & lanes(4'b1100)) !== 32'hBABE_0000) begin errors++; $display("FAIL wrap_b0 got %h/%b/%h exp fffffffc/1100/babe----", a_mem_addr, a_mem_be, a_mem_wdata); end
    ack_a();
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'h0000_0000 || a_mem_be !== 4'b0011 || (a_mem_wdata & lanes(4'b0011)) !== 32'h0000_CAFE) begin errors++; $display("FAIL wrap_b1 got %h/%b/%h exp 00000000/0011/----cafe", a_mem_addr, a_mem_be, a_mem_wdata); end
    ack_a();
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL wrap_done got done=%b err=%b exp 1 0", a_done, a_err); end
  endtask

  task automatic test_back_to_back();
    // Stray ack while idle must have no effect
    @(negedge clk);
    ack_a();
    @(negedge clk);
    checks++; if (a_done !== 1'b0 || a_mem_req !== 1'b0) begin errors++; $display("FAIL stray_ack got done=%b req=%b exp 0 0", a_done, a_mem_req); end
    send_a(3'b000, 32'h0000_2001, 32'hFFFF_FF5A);
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'h0000_2000 || a_mem_be !== 4'b0010 || (a_mem_wdata & lanes(4'b0010)) !== 32'h0000_5A00) begin errors++; $display("FAIL b2b_sb got %h/%b/%h exp 00002000/0010/--5a--", a_mem_addr, a_mem_be, a_mem_wdata); end
    ack_a();
    send_a(3'b001, 32'h0000_2000, 32'h0000_BEEF);
    @(negedge clk);
    checks++; if (a_mem_req !== 1'b1 || a_mem_be !== 4'b0011 || (a_mem_wdata & lanes(4'b0011)) !== 32'h0000_BEEF) begin errors++; $display("FAIL b2b_sh got req=%b %b/%h exp 1 0011/----beef", a_mem_req, a_mem_be, a_mem_wdata); end
    ack_a();
    @(negedge clk);
    checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL b2b_done got done=%b err=%b exp 1 0", a_done, a_err); end
  endtask

  initial begin
    a_req_valid = 1'b0; a_mem_ack = 1'b0; a_instr = 32'h0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req_valid = 1'b0; b_mem_ack = 1'b0; b_instr = 32'h0; b_addr = 32'h0; b_wdata = 32'h0;
    test_reset();
    test_sw_aligned();
    test_sh_sb();
    test_illegal();
    test_split();
    test_nosplit();
    test_delayed_ack();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
